// File: rtl/branch_pc_unit_if.sv
// branch_pc_unit_if: control-unit bus to the branch/PC stage
interface branch_pc_unit_if;
   logic        start;
   logic [31:0] IR_Out;
   logic        con;
   logic        con_en;
   logic        pc_inc;
   logic        pc_load;
   logic [31:0] pc_in;
   logic [31:0] pc_out;
   logic        busy;
   logic        done;
   logic        taken;
   modport master (output start, IR_Out, con, pc_inc, pc_load, pc_in,
                   input  con_en, pc_out, busy, done, taken);
   modport slave  (input  start, IR_Out, con, pc_inc, pc_load, pc_in,
                   output con_en, pc_out, busy, done, taken);
endinterface

// File: rtl/branch_pc_unit.sv
// branch_pc_unit: PC register with CON-FF driven conditional branch resolution
module branch_pc_unit #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
   input logic              clock,
   input logic              clear,
   branch_pc_unit_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, EVAL, RESOLVE} state_t;
   state_t      state;
   logic [31:0] pc;
   logic [22:0] ir_q;
   logic        con_en_q, done_q, taken_q;
   logic        cond_ok;
   logic [31:0] target;
   assign cond_ok = ir_q[22:21] == 2'b00;
   assign target  = pc + {{13{ir_q[18]}}, ir_q[18:0]};
   // branch sequencer, PC update and registered status pulses
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state    <= IDLE;
         pc       <= PC_RESET;
         ir_q     <= '0;
         con_en_q <= 1'b0;
         done_q   <= 1'b0;
         taken_q  <= 1'b0;
      end else begin
         con_en_q <= 1'b0;
         done_q   <= 1'b0;
         taken_q  <= 1'b0;
         case (state)
            IDLE: begin
               pc <= bus.pc_load ? bus.pc_in : bus.pc_inc ? pc + 32'd1 : pc;
               if (bus.start) begin
                  ir_q     <= bus.IR_Out[22:0];
                  con_en_q <= 1'b1;
                  state    <= EVAL;
               end
            end
            EVAL: state <= RESOLVE;
            RESOLVE: begin
               if (cond_ok && bus.con) begin
                  pc      <= target;
                  taken_q <= 1'b1;
               end
               done_q <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
   assign bus.pc_out = pc;
   assign bus.con_en = con_en_q;
   assign bus.busy   = state != IDLE;
   assign bus.done   = done_q;
   assign bus.taken  = taken_q;
endmodule

// File: tb/tb_branch_pc_unit.sv
// tb_branch_pc_unit: directed plus randomized checks against a behavioural model
module tb_branch_pc_unit;
   logic clock = 1'b0;
   logic clear = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   logic [31:0] m_pc;
   int          m_left;
   logic [22:0] m_ir;
   logic        m_done, m_taken;
   branch_pc_unit_if bus ();
   branch_pc_unit #(.PC_RESET(32'h0)) dut (.clock(clock), .clear(clear), .bus(bus));
   always #5 clock = ~clock;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] mk_ir(input int cond, input logic [18:0] c);
      return {9'd0, 4'(cond), c};
   endfunction
   task automatic model_reset();
      m_pc = 32'h0; m_left = 0; m_ir = '0; m_done = 0; m_taken = 0;
   endtask
   task automatic model_edge(input logic s, input logic [31:0] ir, input logic c,
                             input logic i, input logic l, input logic [31:0] p);
      longint off;
      m_done = 0; m_taken = 0;
      if (m_left == 0) begin
         if (l) m_pc = p;
         else if (i) m_pc = m_pc + 1;
         if (s) begin m_ir = ir[22:0]; m_left = 2; end
      end else if (m_left == 2) begin
         m_left = 1;
      end else begin
         off = m_ir[18] ? longint'(m_ir[18:0]) - 524288 : longint'(m_ir[18:0]);
         if (int'(m_ir[22:19]) <= 3 && c) begin
            m_pc = 32'(longint'(m_pc) + off);
            m_taken = 1;
         end
         m_done = 1;
         m_left = 0;
      end
   endtask
   task automatic compare_all();
      check("pc_out", bus.pc_out, m_pc);
      check("con_en", 32'(bus.con_en), 32'(m_left == 2));
      check("busy", 32'(bus.busy), 32'(m_left != 0));
      check("done", 32'(bus.done), 32'(m_done));
      check("taken", 32'(bus.taken), 32'(m_taken));
   endtask
   task automatic step(input logic s, input logic [31:0] ir, input logic c,
                       input logic i, input logic l, input logic [31:0] p);
      bus.start = s; bus.IR_Out = ir; bus.con = c;
      bus.pc_inc = i; bus.pc_load = l; bus.pc_in = p;
      @(posedge clock);
      model_edge(s, ir, c, i, l, p);
      @(negedge clock);
      compare_all();
   endtask
   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, $urandom, $urandom_range(0, 1), 0, 0, $urandom);
   endtask
   task automatic branch(input logic [31:0] ir, input logic c);
      step(1, ir, c, 0, 0, 0);
      step(0, $urandom, c, 0, 0, 0);
      step(0, $urandom, c, 0, 0, 0);
   endtask
   task automatic mid_clear();
      #2 clear = 1'b1;
      #1;
      model_reset();
      check("clr_pc", bus.pc_out, 32'h0);
      check("clr_busy", 32'(bus.busy), 32'h0);
      check("clr_con_en", 32'(bus.con_en), 32'h0);
      check("clr_done", 32'(bus.done), 32'h0);
      check("clr_taken", 32'(bus.taken), 32'h0);
      #1 clear = 1'b0;
   endtask
   initial begin
      bus.start = 0; bus.IR_Out = 0; bus.con = 0;
      bus.pc_inc = 0; bus.pc_load = 0; bus.pc_in = 0;
      model_reset();
      @(negedge clock);
      @(negedge clock);
      compare_all();
      clear = 1'b0;
      step(0, 0, 0, 0, 1, 32'h10);
      step(1, mk_ir(0, 19'h5), 1, 0, 0, 0);
      check("brzr_con_en", 32'(bus.con_en), 32'h1);
      step(0, 0, 1, 0, 0, 0);
      check("brzr_con_en_off", 32'(bus.con_en), 32'h0);
      step(0, 0, 1, 0, 0, 0);
      check("brzr_pc", bus.pc_out, 32'h15);
      check("brzr_taken", 32'(bus.taken), 32'h1);
      step(0, 0, 0, 0, 1, 32'h20);
      branch(mk_ir(1, 19'h7), 0);
      check("brnz_pc", bus.pc_out, 32'h20);
      check("brnz_done", 32'(bus.done), 32'h1);
      check("brnz_taken", 32'(bus.taken), 32'h0);
      step(0, 0, 0, 0, 1, 32'h2);
      branch(mk_ir(3, 19'h7FFFC), 1);
      check("neg_pc", bus.pc_out, 32'hFFFF_FFFE);
      check("neg_taken", 32'(bus.taken), 32'h1);
      step(1, mk_ir(7, 19'h3), 1, 0, 0, 0);
      step(1, mk_ir(0, 19'h9), 1, 1, 1, 32'h999);
      step(1, mk_ir(0, 19'h9), 1, 1, 1, 32'h999);
      check("inv_pc", bus.pc_out, 32'hFFFF_FFFE);
      check("inv_done", 32'(bus.done), 32'h1);
      check("inv_taken", 32'(bus.taken), 32'h0);
      step(0, 0, 0, 0, 1, 32'hFFFF_FFFF);
      step(0, 0, 0, 1, 0, 0);
      check("inc_wrap", bus.pc_out, 32'h0);
      step(0, 0, 0, 1, 1, 32'h100);
      check("load_prio", bus.pc_out, 32'h100);
      step(0, 0, 0, 0, 1, 32'h8);
      step(1, mk_ir(0, 19'h2), 1, 1, 0, 0);
      step(0, mk_ir(1, 19'h40), 1, 0, 0, 0);
      step(0, mk_ir(1, 19'h40), 1, 0, 0, 0);
      check("start_inc_pc", bus.pc_out, 32'hB);
      step(0, 0, 0, 0, 1, 32'h40);
      step(1, mk_ir(0, 19'h4), 1, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      mid_clear();
      step(0, 0, 1, 0, 0, 0);
      check("post_clr_done", 32'(bus.done), 32'h0);
      check("post_clr_pc", bus.pc_out, 32'h0);
      idle(2);
      for (int k = 0; k < 600; k++) begin
         step($urandom_range(0, 3) == 0,
              mk_ir($urandom_range(0, 5), 19'($urandom)),
              $urandom_range(0, 1), $urandom_range(0, 2) == 0,
              $urandom_range(0, 4) == 0, $urandom);
         if ($urandom_range(0, 60) == 0) mid_clear();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
